// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD SPI-mode command sequencer.
//   sd_state_e   : sequencer states (idle, power-up clocks, preamble,
//                  command frame, response hunt, trailing clocks)
//   SD_FILL      : idle/fill byte on the SPI bus
//   SD_CRC_CMD*  : precomputed CRC7 values for the fixed-argument commands
//   SD_R1_IDLE   : R1 value reported by a card in the idle state
//   sd_frame()   : assembles the 48-bit command frame
package sd_pkg;

    typedef enum logic [2:0] {
        SD_IDLE,
        SD_INIT,
        SD_PRE,
        SD_SEND,
        SD_WAIT,
        SD_POST
    } sd_state_e;

    localparam logic [7:0] SD_FILL     = 8'hFF;
    localparam logic [6:0] SD_CRC_CMD0 = 7'h4A;
    localparam logic [6:0] SD_CRC_CMD8 = 7'h43;
    localparam logic [7:0] SD_R1_IDLE  = 8'h01;

    // Width of the bit and byte counters; wide enough for any sane
    // INIT_CLOCKS or RESP_TIMEOUT setting.
    localparam int SD_CNT_W = 16;

    // Start bit 0, transmission bit 1, index, argument, CRC7, end bit 1.
    function automatic logic [47:0] sd_frame(input logic [5:0]  idx,
                                             input logic [31:0] arg,
                                             input logic [6:0]  crc);
        return {2'b01, idx, arg, crc, 1'b1};
    endfunction

endpackage

// File: rtl/sd_spi_clkgen.sv
// sd_spi_clkgen: SPI serial clock generator.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   en_i   : run the clock; while low SdClk is held low and the phase
//            counter is cleared, so every enable starts a fresh half-period
//   sclk_o : serial clock, idles low, half-period CLKDIV clk_i cycles
//   rise_o : one-cycle pulse in the first cycle sclk_o is high
//   fall_o : one-cycle pulse in the last cycle sclk_o is high, so registers
//            updated on it change on the same edge as the falling sclk_o
module sd_spi_clkgen #(
    parameter int CLKDIV = 63
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          rise_q, rise_d;
    logic          halfDone;

    // Half-period counter; the toggle happens on the edge that ends the
    // last cycle of each half-period.
    always_comb begin
        halfDone = (cnt_q == CW'(CLKDIV - 1));
        cnt_d    = halfDone ? '0 : cnt_q + CW'(1);
        sclk_d   = halfDone ? ~sclk_q : sclk_q;
        rise_d   = halfDone && !sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
            rise_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
            rise_q <= rise_d;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = rise_q;
    assign fall_o = en_i && halfDone && sclk_q;

endmodule

// File: rtl/sd_spi_cmd.sv
// sd_spi_cmd: SPI-mode command sequencer owning the micro-SD pads.
//   CKA50 / RST            : system clock, synchronous active-high reset
//   Init                   : request the power-up clock burst (CS high)
//   CmdValid / CmdReady    : command handshake, accepted only when idle
//   CmdIdx / CmdArg / CmdCrc : command frame fields, latched at accept
//   Busy                   : transaction or power-up burst in progress
//   RespValid / Resp / RespTimeout : one-cycle result pulse, held values
//   SdClk, SdCmdOut/En, SdDat0In/En, SdDat3Out/En : pad-level signals
// A transaction is 8 fill clocks, the 48-bit frame, byte-aligned R1 polling
// and 8 trailing clocks, all in SPI mode 0.
module sd_spi_cmd
    import sd_pkg::*;
#(
    parameter int CLKDIV       = 63,
    parameter int RESP_TIMEOUT = 8,
    parameter int INIT_CLOCKS  = 80
) (
    input  logic        CKA50,
    input  logic        RST,
    input  logic        Init,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [5:0]  CmdIdx,
    input  logic [31:0] CmdArg,
    input  logic [6:0]  CmdCrc,
    output logic        Busy,
    output logic        RespValid,
    output logic [7:0]  Resp,
    output logic        RespTimeout,
    output logic        SdClk,
    output logic        SdCmdOut,
    output logic        SdCmdEn,
    input  logic        SdDat0In,
    output logic        SdDat0En,
    output logic        SdDat3Out,
    output logic        SdDat3En
);

    sd_state_e             state_q, state_d;
    logic [47:0]           shift_q, shift_d;
    logic [SD_CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [SD_CNT_W-1:0]   byteCnt_q, byteCnt_d;
    logic [7:0]            rx_q, rx_d;
    logic                  toutFlag_q, toutFlag_d;
    logic [7:0]            resp_q, resp_d;
    logic                  respTimeout_q, respTimeout_d;
    logic                  respValid_q, respValid_d;
    logic                  sclkEn, sclkRise, sclkFall;

    // The serial clock only runs outside IDLE, so each burst restarts
    // with a full low half-period.
    assign sclkEn = (state_q != SD_IDLE);

    sd_spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk_i  (CKA50),
        .rst_i  (RST),
        .en_i   (sclkEn),
        .sclk_o (SdClk),
        .rise_o (sclkRise),
        .fall_o (sclkFall)
    );

    // Next-state logic. Every phase advances on SdClk falling edges, so the
    // last falling edge of a phase is also the edge that moves MOSI/CS on.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bitCnt_d      = bitCnt_q;
        byteCnt_d     = byteCnt_q;
        rx_d          = rx_q;
        toutFlag_d    = toutFlag_q;
        resp_d        = resp_q;
        respTimeout_d = respTimeout_q;
        respValid_d   = 1'b0;

        unique case (state_q)
            SD_IDLE: begin
                bitCnt_d = '0;
                if (Init) begin
                    state_d = SD_INIT;
                end else if (CmdValid) begin
                    state_d    = SD_PRE;
                    shift_d    = sd_frame(CmdIdx, CmdArg, CmdCrc);
                    byteCnt_d  = '0;
                    toutFlag_d = 1'b0;
                end
            end
            SD_INIT: begin
                if (sclkFall) begin
                    if (bitCnt_q == SD_CNT_W'(INIT_CLOCKS - 1)) begin
                        bitCnt_d = '0;
                        state_d  = SD_IDLE;
                    end else begin
                        bitCnt_d = bitCnt_q + SD_CNT_W'(1);
                    end
                end
            end
            SD_PRE: begin
                if (sclkFall) begin
                    if (bitCnt_q == SD_CNT_W'(7)) begin
                        bitCnt_d = '0;
                        state_d  = SD_SEND;
                    end else begin
                        bitCnt_d = bitCnt_q + SD_CNT_W'(1);
                    end
                end
            end
            SD_SEND: begin
                if (sclkFall) begin
                    shift_d = {shift_q[46:0], 1'b1};
                    if (bitCnt_q == SD_CNT_W'(47)) begin
                        bitCnt_d = '0;
                        state_d  = SD_WAIT;
                    end else begin
                        bitCnt_d = bitCnt_q + SD_CNT_W'(1);
                    end
                end
            end
            SD_WAIT: begin
                // The byte decision is taken on the falling edge after the
                // eighth sample, when rx_q already holds the complete byte.
                if (sclkRise) begin
                    rx_d = {rx_q[6:0], SdDat0In};
                end
                if (sclkFall) begin
                    if (bitCnt_q == SD_CNT_W'(7)) begin
                        bitCnt_d = '0;
                        if (!rx_q[7]) begin
                            state_d = SD_POST;
                        end else if (byteCnt_q == SD_CNT_W'(RESP_TIMEOUT - 1)) begin
                            toutFlag_d = 1'b1;
                            state_d    = SD_POST;
                        end else begin
                            byteCnt_d = byteCnt_q + SD_CNT_W'(1);
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + SD_CNT_W'(1);
                    end
                end
            end
            SD_POST: begin
                // Results are published only here so Resp/RespTimeout keep
                // their previous values for the whole transaction.
                if (sclkFall) begin
                    if (bitCnt_q == SD_CNT_W'(7)) begin
                        bitCnt_d      = '0;
                        state_d       = SD_IDLE;
                        respValid_d   = 1'b1;
                        resp_d        = toutFlag_q ? SD_FILL : rx_q;
                        respTimeout_d = toutFlag_q;
                    end else begin
                        bitCnt_d = bitCnt_q + SD_CNT_W'(1);
                    end
                end
            end
            default: state_d = SD_IDLE;
        endcase
    end

    always_ff @(posedge CKA50) begin
        if (RST) begin
            state_q       <= SD_IDLE;
            shift_q       <= '1;
            bitCnt_q      <= '0;
            byteCnt_q     <= '0;
            rx_q          <= SD_FILL;
            toutFlag_q    <= 1'b0;
            resp_q        <= SD_FILL;
            respTimeout_q <= 1'b0;
            respValid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bitCnt_q      <= bitCnt_d;
            byteCnt_q     <= byteCnt_d;
            rx_q          <= rx_d;
            toutFlag_q    <= toutFlag_d;
            resp_q        <= resp_d;
            respTimeout_q <= respTimeout_d;
            respValid_q   <= respValid_d;
        end
    end

    assign CmdReady    = (state_q == SD_IDLE);
    assign Busy        = (state_q != SD_IDLE);
    assign RespValid   = respValid_q;
    assign Resp        = resp_q;
    assign RespTimeout = respTimeout_q;

    // Chip select is low for the whole card transaction; MOSI only carries
    // data during the frame and idles high otherwise.
    assign SdDat3Out = (state_q == SD_IDLE) || (state_q == SD_INIT);
    assign SdCmdOut  = (state_q == SD_SEND) ? shift_q[47] : 1'b1;
    assign SdCmdEn   = 1'b1;
    assign SdDat0En  = 1'b0;
    assign SdDat3En  = 1'b1;

endmodule
